// File: rtl/rom_toggle_responder_pkg.sv
// Shared types and constants for the toggle-handshake ROM/memory responder.
package rom_toggle_responder_pkg;

    localparam int LINE_W         = 64;
    localparam int WORD_W         = 16;
    localparam int WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } state_e;

    // Word n of a line occupies bits [16n+15:16n].
    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        sel);
        return line[{sel, 4'b0000} +: WORD_W];
    endfunction

endpackage

// File: rtl/rom_toggle_responder_if.sv
// Host request/acknowledge signals and the 64-bit memory port, bundled together.
//
// Handshake: a host request is pending while req != ack. The responder samples
// the request's address/data at issue (the host keeps them stable until ack)
// and completes it by making ack equal to req. On the memory side, mem_rd or
// mem_we is held until an edge where mem_busy is 0; that edge accepts the
// transaction. Read data comes back later with a one-cycle mem_dout_ready.
interface rom_toggle_responder_if;
    import rom_toggle_responder_pkg::*;

    logic [24:0] wraddr;
    logic [15:0] din;
    logic        we_req;
    logic        we_ack;
    logic [22:1] rdaddr;
    logic [15:0] dout;
    logic        rd_req;
    logic        rd_ack;

    logic [21:0] mem_addr;
    logic        mem_busy;
    logic        mem_rd;
    logic        mem_we;
    logic [63:0] mem_din;
    logic [7:0]  mem_be;
    logic [63:0] mem_dout;
    logic        mem_dout_ready;

    state_e      dbg_state;

    modport slave (
        input  wraddr, din, we_req, rdaddr, rd_req,
        input  mem_busy, mem_dout, mem_dout_ready,
        output we_ack, dout, rd_ack,
        output mem_addr, mem_rd, mem_we, mem_din, mem_be,
        output dbg_state
    );

    modport master (
        output wraddr, din, we_req, rdaddr, rd_req,
        output mem_busy, mem_dout, mem_dout_ready,
        input  we_ack, dout, rd_ack,
        input  mem_addr, mem_rd, mem_we, mem_din, mem_be,
        input  dbg_state
    );

endinterface

// File: rtl/rom_line_cache.sv
// One-line 64-bit read cache: tag, valid, line data, word select, invalidate.
module rom_line_cache
    import rom_toggle_responder_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [19:0]       lookup_tag_i,
    input  logic [1:0]        word_sel_i,
    input  logic              fill_en_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic              inv_en_i,
    input  logic [21:0]       inv_tag_i,
    output logic              hit_o,
    output logic [WORD_W-1:0] hit_word_o
);

    // With the cache disabled the line never becomes valid, so every read misses.
    localparam logic CACHE_ON = (CACHE_EN != 0);

    logic              valid_q;
    logic [19:0]       tag_q;
    logic [LINE_W-1:0] line_q;

    // Valid bit: set on fill, cleared by reset or a write that lands in the cached line.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else if (fill_en_i) begin
            valid_q <= CACHE_ON;
        end else if (inv_en_i && (inv_tag_i == {2'b00, tag_q})) begin
            valid_q <= 1'b0;
        end
    end

    // Tag and line data captured from each completed memory read.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tag_q  <= '0;
            line_q <= '0;
        end else if (fill_en_i) begin
            tag_q  <= lookup_tag_i;
            line_q <= fill_line_i;
        end
    end

    assign hit_o      = valid_q && (tag_q == lookup_tag_i);
    assign hit_word_o = line_word(line_q, word_sel_i);

endmodule

// File: rtl/rom_toggle_responder.sv
// Toggle-handshake responder: turns 16-bit host reads/writes into 64-bit
// memory transactions, with an optional one-line read cache.
module rom_toggle_responder
    import rom_toggle_responder_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    rom_toggle_responder_if.slave bus
);

    state_e            state_q, state_d;
    logic              we_ack_q, we_ack_d;
    logic              rd_ack_q, rd_ack_d;
    logic [WORD_W-1:0] dout_q, dout_d;

    logic              wr_pend, rd_pend;
    logic              cache_hit, fill_en, inv_en;
    logic [WORD_W-1:0] hit_word;
    logic              unused_wraddr_b0;

    assign wr_pend          = (bus.we_req != we_ack_q);
    assign rd_pend          = (bus.rd_req != rd_ack_q);
    // Writes are always 16-bit aligned; the byte-select bit carries no meaning.
    assign unused_wraddr_b0 = bus.wraddr[0];

    rom_line_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .lookup_tag_i (bus.rdaddr[22:3]),
        .word_sel_i   (bus.rdaddr[2:1]),
        .fill_en_i    (fill_en),
        .fill_line_i  (bus.mem_dout),
        .inv_en_i     (inv_en),
        .inv_tag_i    (bus.wraddr[24:3]),
        .hit_o        (cache_hit),
        .hit_word_o   (hit_word)
    );

    // State, acknowledge toggles and read data register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            we_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            we_ack_q <= we_ack_d;
            rd_ack_q <= rd_ack_d;
            dout_q   <= dout_d;
        end
    end

    // Next-state logic: writes beat reads in IDLE; hits complete without memory.
    always_comb begin
        state_d  = state_q;
        we_ack_d = we_ack_q;
        rd_ack_d = rd_ack_q;
        dout_d   = dout_q;
        fill_en  = 1'b0;
        inv_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_pend) begin
                    state_d = WR_ISSUE;
                end else if (rd_pend) begin
                    if (cache_hit) begin
                        dout_d   = hit_word;
                        rd_ack_d = bus.rd_req;
                    end else begin
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                if (!bus.mem_busy) begin
                    state_d  = IDLE;
                    we_ack_d = bus.we_req;
                    inv_en   = 1'b1;
                end
            end
            RD_ISSUE: begin
                if (!bus.mem_busy) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Ready is only honoured here; stray pulses elsewhere fall through.
                if (bus.mem_dout_ready) begin
                    fill_en  = 1'b1;
                    dout_d   = line_word(bus.mem_dout, bus.rdaddr[2:1]);
                    rd_ack_d = bus.rd_req;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_we    = (state_q == WR_ISSUE);
    assign bus.mem_rd    = (state_q == RD_ISSUE);
    assign bus.mem_addr  = (state_q == WR_ISSUE) ? bus.wraddr[24:3] : {2'b00, bus.rdaddr[22:3]};
    assign bus.mem_din   = {WORDS_PER_LINE{bus.din}};
    assign bus.mem_be    = (state_q == WR_ISSUE) ? (8'b0000_0011 << {bus.wraddr[2:1], 1'b0}) : 8'h00;
    assign bus.we_ack    = we_ack_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.dout      = dout_q;
    assign bus.dbg_state = state_q;

endmodule
